// File: rtl/lr_car_detector.sv
// lr_car_detector
// Debounced local-road vehicle detector. Two loop sensors (entry before the
// stop line, exit past it) are synchronized and debounced. A filtered rising
// edge on entry counts a car in and one on exit counts a car out. The queue
// count and a "has car" flag go to the traffic light controller.
//
// Optional feature: define LR_CAR_DETECTOR_WATCHDOG_EN to enable a
// stuck-entry-sensor watchdog. It raises a sticky sensor_fault once the
// filtered entry level has been high for 255 consecutive cycles. Without the
// macro, sensor_fault is tied low.
//
// Parameters:
//   DEBOUNCE      consecutive stable synced cycles before a filtered level
//                 changes (2..15)
// Ports:
//   clk           system clock, rising edge
//   rst_n         synchronous active-low reset
//   entry_raw     asynchronous entry loop sensor, 1 = vehicle present
//   exit_raw      asynchronous exit loop sensor, 1 = vehicle present
//   lr_has_car    car_count != 0 or sensor_fault (combinational)
//   car_count     vehicles queued between the loops, saturating 0..15
//   arrive        one-cycle pulse per accepted arrival
//   depart        one-cycle pulse per accepted departure
//   sensor_fault  sticky stuck-entry flag
module lr_car_detector #(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       entry_raw,
  input  logic       exit_raw,
  output logic       lr_has_car,
  output logic [3:0] car_count,
  output logic       arrive,
  output logic       depart,
  output logic       sensor_fault
);

  localparam logic [3:0] DC_LAST = 4'(DEBOUNCE - 1);

  // Bit 0 is the entry sensor and bit 1 is the exit sensor.
  logic [1:0] raw;
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] filt;
  logic [1:0] settle;
  logic [1:0] rise;
  logic [3:0] dc [2];

  assign raw = {exit_raw, entry_raw};

  // settle marks the edge on which filt takes the synced level. rise is the
  // 0->1 subset of those edges, so the count updates on the same edge as filt.
  assign settle = (sync2 ^ filt) & {dc[1] == DC_LAST, dc[0] == DC_LAST};
  assign rise   = settle & sync2;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      filt  <= '0;
      dc[0] <= '0;
      dc[1] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == filt[i]) begin
          dc[i] <= '0;
        end else if (settle[i]) begin
          filt[i] <= sync2[i];
          dc[i]   <= '0;
        end else begin
          dc[i] <= dc[i] + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      car_count <= '0;
      arrive    <= 1'b0;
      depart    <= 1'b0;
    end else begin
      arrive <= rise[0];
      depart <= rise[1];
      unique case (rise)
        2'b01: if (car_count != '1) car_count <= car_count + 4'd1;
        2'b10: if (car_count != '0) car_count <= car_count - 4'd1;
        default: car_count <= car_count;
      endcase
    end
  end

`ifdef LR_CAR_DETECTOR_WATCHDOG_EN
  logic [7:0] wd;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wd           <= '0;
      sensor_fault <= 1'b0;
    end else begin
      if (!filt[0]) begin
        wd <= '0;
      end else if (wd != '1) begin
        wd <= wd + 8'd1;
      end
      if (filt[0] && (wd == 8'd254)) begin
        sensor_fault <= 1'b1;
      end
    end
  end
`else
  assign sensor_fault = 1'b0;
`endif

  assign lr_has_car = (car_count != '0) | sensor_fault;

endmodule

// File: tb/tb_lr_car_detector.sv
// Directed self-checking bench for lr_car_detector with DEBOUNCE=4.
// Inputs are driven 1 time unit after a rising edge. Outputs are sampled at
// that same point.
module tb_lr_car_detector;

  logic       clk;
  logic       rst_n;
  logic       entry_raw;
  logic       exit_raw;
  logic       lr_has_car;
  logic [3:0] car_count;
  logic       arrive;
  logic       depart;
  logic       sensor_fault;

  int checks = 0;
  int errors = 0;
  int arrive_cnt = 0;
  int depart_cnt = 0;

  lr_car_detector #(.DEBOUNCE(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .entry_raw    (entry_raw),
    .exit_raw     (exit_raw),
    .lr_has_car   (lr_has_car),
    .car_count    (car_count),
    .arrive       (arrive),
    .depart       (depart),
    .sensor_fault (sensor_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (arrive === 1'b1) arrive_cnt++;
    if (depart === 1'b1) depart_cnt++;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running, want finished");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  // Raise the selected sensors. Six edges later the filtered level rises, so
  // the pulse outputs are sampled then. The sensors then drop and settle low.
  task automatic pulse(input logic en, input logic ex, output logic a,
                       output logic d, output logic [3:0] cnt);
    entry_raw = en;
    exit_raw  = ex;
    step(6);
    a   = arrive;
    d   = depart;
    cnt = car_count;
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    step(8);
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (car_count !== 4'd0 || arrive !== 1'b0 || depart !== 1'b0 ||
        lr_has_car !== 1'b0 || sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got cnt=%0d arr=%b dep=%b has=%b flt=%b, want all 0",
               car_count, arrive, depart, lr_has_car, sensor_fault);
    end
  endtask

  task automatic test_arrival_latency();
    rst_n     = 1'b0;
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    step(2);
    // The entry sensor is high at reset release, so it is seen as a fresh arrival.
    rst_n     = 1'b1;
    entry_raw = 1'b1;
    for (int e = 1; e <= 5; e++) begin
      step(1);
      checks++;
      if (car_count !== 4'd0 || arrive !== 1'b0) begin
        errors++;
        $display("FAIL early_arrival edge %0d: got cnt=%0d arr=%b, want cnt=0 arr=0",
                 e, car_count, arrive);
      end
    end
    step(1);
    checks++;
    if (car_count !== 4'd1 || lr_has_car !== 1'b1 || arrive !== 1'b1) begin
      errors++;
      $display("FAIL arrival_edge6: got cnt=%0d has=%b arr=%b, want cnt=1 has=1 arr=1",
               car_count, lr_has_car, arrive);
    end
    step(1);
    checks++;
    if (arrive !== 1'b0 || car_count !== 4'd1) begin
      errors++;
      $display("FAIL arrive_width: got arr=%b cnt=%0d, want arr=0 cnt=1", arrive, car_count);
    end
    entry_raw = 1'b0;
    step(8);
  endtask

  task automatic test_glitch();
    int base;
    apply_reset();
    base = arrive_cnt;
    entry_raw = 1'b1;
    step(3);
    entry_raw = 1'b0;
    step(12);
    checks++;
    if (car_count !== 4'd0 || arrive_cnt != base) begin
      errors++;
      $display("FAIL glitch: got cnt=%0d arrives=%0d, want cnt=0 arrives=0",
               car_count, arrive_cnt - base);
    end
  endtask

  task automatic test_fill_drain();
    logic a, d;
    logic [3:0] cnt;
    int abase, dbase;
    apply_reset();
    abase = arrive_cnt;
    dbase = depart_cnt;
    for (int i = 0; i < 5; i++) pulse(1'b1, 1'b0, a, d, cnt);
    checks++;
    if (car_count !== 4'd5 || arrive_cnt - abase != 5) begin
      errors++;
      $display("FAIL fill: got cnt=%0d arrives=%0d, want cnt=5 arrives=5",
               car_count, arrive_cnt - abase);
    end
    for (int i = 0; i < 7; i++) begin
      pulse(1'b0, 1'b1, a, d, cnt);
      checks++;
      if (cnt !== ((i < 5) ? 4'(4 - i) : 4'd0) || d !== 1'b1) begin
        errors++;
        $display("FAIL drain %0d: got cnt=%0d dep=%b, want cnt=%0d dep=1",
                 i, cnt, d, (i < 5) ? 4 - i : 0);
      end
    end
    checks++;
    if (car_count !== 4'd0 || lr_has_car !== 1'b0 || depart_cnt - dbase != 7) begin
      errors++;
      $display("FAIL drained: got cnt=%0d has=%b departs=%0d, want cnt=0 has=0 departs=7",
               car_count, lr_has_car, depart_cnt - dbase);
    end
  endtask

  task automatic test_saturate();
    logic a, d;
    logic [3:0] cnt;
    apply_reset();
    for (int i = 0; i < 17; i++) begin
      pulse(1'b1, 1'b0, a, d, cnt);
      if (i >= 13) begin
        checks++;
        if (cnt !== ((i < 15) ? 4'(i + 1) : 4'd15) || a !== 1'b1) begin
          errors++;
          $display("FAIL saturate %0d: got cnt=%0d arr=%b, want cnt=%0d arr=1",
                   i, cnt, a, (i < 15) ? i + 1 : 15);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic a, d;
    logic [3:0] cnt;
    apply_reset();
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b0, a, d, cnt);
    pulse(1'b1, 1'b1, a, d, cnt);
    checks++;
    if (cnt !== 4'd3 || a !== 1'b1 || d !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous: got cnt=%0d arr=%b dep=%b, want cnt=3 arr=1 dep=1",
               cnt, a, d);
    end
  endtask

  task automatic test_reset_mid();
    logic a, d;
    logic [3:0] cnt;
    int abase, dbase;
    apply_reset();
    for (int i = 0; i < 4; i++) pulse(1'b1, 1'b0, a, d, cnt);
    entry_raw = 1'b1;
    step(3);
    rst_n     = 1'b0;
    entry_raw = 1'b0;
    step(1);
    checks++;
    if (car_count !== 4'd0 || lr_has_car !== 1'b0 || arrive !== 1'b0 || depart !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: got cnt=%0d has=%b arr=%b dep=%b, want all 0",
               car_count, lr_has_car, arrive, depart);
    end
    rst_n = 1'b1;
    abase = arrive_cnt;
    dbase = depart_cnt;
    step(12);
    checks++;
    if (car_count !== 4'd0 || arrive_cnt != abase || depart_cnt != dbase) begin
      errors++;
      $display("FAIL post_reset_quiet: got cnt=%0d arrives=%0d departs=%0d, want 0 0 0",
               car_count, arrive_cnt - abase, depart_cnt - dbase);
    end
  endtask

`ifdef LR_CAR_DETECTOR_WATCHDOG_EN
  task automatic test_watchdog();
    logic a, d;
    logic [3:0] cnt;
    apply_reset();
    entry_raw = 1'b1;
    step(100);
    checks++;
    if (sensor_fault !== 1'b0) begin
      errors++;
      $display("FAIL fault_early: got flt=%b, want 0", sensor_fault);
    end
    step(200);
    checks++;
    if (sensor_fault !== 1'b1 || lr_has_car !== 1'b1 || car_count !== 4'd1) begin
      errors++;
      $display("FAIL fault_set: got flt=%b has=%b cnt=%0d, want flt=1 has=1 cnt=1",
               sensor_fault, lr_has_car, car_count);
    end
    entry_raw = 1'b0;
    step(8);
    pulse(1'b0, 1'b1, a, d, cnt);
    checks++;
    if (car_count !== 4'd0 || lr_has_car !== 1'b1 || sensor_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: got cnt=%0d has=%b flt=%b, want cnt=0 has=1 flt=1",
               car_count, lr_has_car, sensor_fault);
    end
    rst_n = 1'b0;
    step(1);
    checks++;
    if (sensor_fault !== 1'b0 || lr_has_car !== 1'b0 || car_count !== 4'd0 ||
        arrive !== 1'b0 || depart !== 1'b0) begin
      errors++;
      $display("FAIL fault_reset: got flt=%b has=%b cnt=%0d arr=%b dep=%b, want all 0",
               sensor_fault, lr_has_car, car_count, arrive, depart);
    end
    rst_n = 1'b1;
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    entry_raw = 1'b0;
    exit_raw  = 1'b0;
    test_reset();
    test_arrival_latency();
    test_glitch();
    test_fill_drain();
    test_saturate();
    test_back_to_back();
    test_reset_mid();
`ifdef LR_CAR_DETECTOR_WATCHDOG_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lr_car_detector.md
LR_CAR_DETECTOR -- requirements
Module: lr_car_detector

Interface
REQ-001 Parameter DEBOUNCE, default 4 (legal 2..15): consecutive stable cycles required before a filtered sensor level changes.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low; clock clk.
REQ-004 entry_raw  input  1  asynchronous local-road entry loop sensor, 1 = vehicle over loop.
REQ-005 exit_raw  input  1  asynchronous local-road exit loop sensor (past stop line), 1 = vehicle over loop.
REQ-006 lr_has_car  output  1  local road has a waiting vehicle; feeds the traffic light controller.
REQ-007 car_count  output  4  registered number of vehicles queued between the entry and exit loops.
REQ-008 arrive  output  1  registered one-cycle pulse per accepted arrival.
REQ-009 depart  output  1  registered one-cycle pulse per accepted departure.
REQ-010 sensor_fault  output  1  sticky stuck-entry-sensor flag.

Function
REQ-011 Each raw input SHALL pass through a two-flop synchronizer; the second flop output is the synced level s.
REQ-012 Each sensor SHALL have a filtered level f and a 4-bit debounce counter dc: s==f -> dc<=0; s!=f and dc<DEBOUNCE-1 -> dc<=dc+1; s!=f and dc==DEBOUNCE-1 -> f<=s, dc<=0.
REQ-013 A raw change held stable SHALL update f on the (2+DEBOUNCE)th rising edge after first being sampled; a glitch shorter than DEBOUNCE synced cycles SHALL leave f unchanged.
REQ-014 Arrival event = entry f transitioning 0->1 at an edge; departure event = exit f transitioning 0->1; 1->0 transitions produce no event.
REQ-015 On the same edge as an event, car_count SHALL update: arrival only -> +1, saturating at 15; departure only -> -1, holding at 0; both -> unchanged.
REQ-016 arrive/depart SHALL be 1 for exactly the cycle following their event's edge, including saturated or underflow-ignored events.
REQ-017 lr_has_car SHALL be combinational: (car_count != 0) OR sensor_fault.
REQ-018 Entry and exit paths SHALL be fully independent; simultaneous events on both handled per REQ-015.

Reset
REQ-019 While rst_n=0 at a rising edge: synchronizer flops, f, dc, car_count, arrive, depart, sensor_fault, watchdog counter all <=0.
REQ-020 Reset mid-debounce or with cars queued SHALL discard all history; a raw input held high through reset release SHALL be reported as a fresh arrival after 2+DEBOUNCE edges.

Configuration
REQ-021 Macro LR_CAR_DETECTOR_WATCHDOG_EN defined: 8-bit watchdog counts consecutive cycles with entry f==1, clears when f==0, saturates at 255; on the edge it would reach 255, sensor_fault<=1, sticky until reset.
REQ-022 Macro undefined: no watchdog logic; sensor_fault tied to 0.

Verification
REQ-023 DEBOUNCE=4, reset, entry_raw 0->1 held -> car_count=1 and lr_has_car=1 after edge 6; arrive high for one cycle after edge 6.
REQ-024 entry_raw 3-cycle pulse (clk-aligned) -> car_count stays 0, arrive never asserts.
REQ-025 Five clean arrivals then seven clean departures -> count 5 then 0, lr_has_car=0, seven depart pulses, count never wraps.
REQ-026 Seventeen arrivals -> count saturates at 15; entry and exit toggled simultaneously at count 3 -> count stays 3, both arrive and depart pulse.
REQ-027 With WATCHDOG_EN, entry_raw held high 300 cycles -> sensor_fault=1, lr_has_car=1 with count 1; exit event -> count 0, lr_has_car stays 1; rst_n low one edge -> all outputs 0.
REQ-028 rst_n asserted at count 4 mid-debounce -> outputs 0 next cycle, no spurious arrive/depart after release with inputs low.
